eth_mdio_ctrl: RTL

- MDIO/SMI management master (IEEE 802.3 clause 22) that configures and polls the external RMII PHY attached to the udma_ethernet datapath.
- Accepts one register read or write command at a time on a valid/ready interface and serialises it on MDC/MDIO.
- Returns read data and a TA-error flag on a single-cycle response strobe.
- Sits beside the RMII/MAC core in the same clock domain; the top-level IO pad muxes the tri-state MDIO.

---
 rtl/eth_mdio_pkg.sv | 34 +++
 rtl/eth_mdio_clkgen.sv | 38 +++
 rtl/eth_mdio_ctrl.sv | 120 ++++++++++++
 3 files changed

// File: rtl/eth_mdio_pkg.sv
// rtl/eth_mdio_pkg.sv - shared constants, types and frame builder for the MDIO master
package eth_mdio_pkg;

  localparam logic [1:0] MDIO_OP_WRITE = 2'b01;
  localparam logic [1:0] MDIO_OP_READ  = 2'b10;
  localparam logic [1:0] MDIO_ST       = 2'b01;
  localparam logic [1:0] MDIO_TA_WR    = 2'b10;

  localparam logic [5:0] TA_IDX   = 6'd46;
  localparam logic [5:0] DATA_IDX = 6'd48;
  localparam logic [5:0] LAST_IDX = 6'd63;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FRAME,
    ST_DONE
  } mdio_state_t;

  typedef struct packed {
    logic [1:0]  op;
    logic [4:0]  phy;
    logic [4:0]  regad;
    logic [15:0] wdata;
  } mdio_cmd_t;

  // Read frames carry ones in TA/DATA so the released line idles high.
  function automatic logic [63:0] mdio_frame(input mdio_cmd_t c);
    logic wr;
    wr = (c.op == MDIO_OP_WRITE);
    return {32'hFFFF_FFFF, MDIO_ST, wr ? MDIO_OP_WRITE : MDIO_OP_READ, c.phy, c.regad,
            wr ? MDIO_TA_WR : 2'b11, wr ? c.wdata : 16'hFFFF};
  endfunction

endpackage

// File: rtl/eth_mdio_clkgen.sv
// rtl/eth_mdio_clkgen.sv - MDC divider with rise/fall strobes, held low while disabled
module eth_mdio_clkgen #(
  parameter int CLK_DIV = 20
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic en,
  output logic mdc,
  output logic rise_stb,
  output logic fall_stb
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] div_cnt;
  logic          wrap;

  assign wrap     = en && (div_cnt == DIV_LAST);
  assign rise_stb = wrap && !mdc;
  assign fall_stb = wrap && mdc;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      div_cnt <= '0;
      mdc     <= 1'b0;
    end else if (!en) begin
      div_cnt <= '0;
      mdc     <= 1'b0;
    end else if (wrap) begin
      div_cnt <= '0;
      mdc     <= !mdc;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/eth_mdio_ctrl.sv
// rtl/eth_mdio_ctrl.sv - clause 22 MDIO management master, one command per frame
module eth_mdio_ctrl
  import eth_mdio_pkg::*;
#(
  parameter int CLK_DIV     = 20,
  parameter bit PREAMBLE_EN = 1'b1
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [1:0]  cmd_op_i,
  input  logic [4:0]  cmd_phy_addr_i,
  input  logic [4:0]  cmd_reg_addr_i,
  input  logic [15:0] cmd_wdata_i,
  output logic        rsp_valid_o,
  output logic [15:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic        busy_o,
  output logic        mdc_o,
  output logic        mdio_o,
  output logic        mdio_oe_o,
  input  logic        mdio_i
);

  // Bit counter holds the absolute frame index, so a short frame starts at 32.
  localparam logic [5:0] FIRST_BIT = PREAMBLE_EN ? 6'd0 : 6'd32;

  mdio_state_t state;
  mdio_cmd_t   cmd_in;
  logic [63:0] frame_full;
  logic [63:0] frame_load;
  logic [62:0] shift_q;
  logic [5:0]  bit_cnt;
  logic [5:0]  next_bit;
  logic [15:0] rx_data;
  logic        ta_err;
  logic        is_write;
  logic        accept;
  logic        rise_stb;
  logic        fall_stb;

  assign cmd_in     = {cmd_op_i, cmd_phy_addr_i, cmd_reg_addr_i, cmd_wdata_i};
  assign frame_full = mdio_frame(cmd_in);
  assign frame_load = PREAMBLE_EN ? frame_full : {frame_full[31:0], 32'hFFFF_FFFF};
  assign accept     = cmd_valid_i && cmd_ready_o;
  assign next_bit   = bit_cnt + 6'd1;

  eth_mdio_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
    .clk_i    (clk_i),
    .rstn_i   (rstn_i),
    .en       (state == ST_FRAME),
    .mdc      (mdc_o),
    .rise_stb (rise_stb),
    .fall_stb (fall_stb)
  );

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state       <= ST_IDLE;
      shift_q     <= '1;
      bit_cnt     <= '0;
      rx_data     <= '0;
      ta_err      <= 1'b0;
      is_write    <= 1'b0;
      cmd_ready_o <= 1'b1;
      rsp_valid_o <= 1'b0;
      rsp_rdata_o <= '0;
      rsp_err_o   <= 1'b0;
      busy_o      <= 1'b0;
      mdio_o      <= 1'b1;
      mdio_oe_o   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          rsp_valid_o <= 1'b0;
          if (accept) begin
            state       <= ST_FRAME;
            shift_q     <= frame_load[62:0];
            bit_cnt     <= FIRST_BIT;
            is_write    <= (cmd_op_i == MDIO_OP_WRITE);
            rx_data     <= '0;
            ta_err      <= 1'b0;
            cmd_ready_o <= 1'b0;
            busy_o      <= 1'b1;
            mdio_o      <= frame_load[63];
            mdio_oe_o   <= 1'b1;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_FRAME: begin
          if (rise_stb && !is_write) begin
            if (bit_cnt == TA_IDX + 6'd1) ta_err <= mdio_i;
            if (bit_cnt >= DATA_IDX)      rx_data <= {rx_data[14:0], mdio_i};
          end
          if (fall_stb) begin
            if (bit_cnt == LAST_IDX) begin
              state       <= ST_DONE;
              rsp_valid_o <= 1'b1;
              rsp_err_o   <= !is_write && ta_err;
              if (!is_write) rsp_rdata_o <= rx_data;
              cmd_ready_o <= 1'b1;
              busy_o      <= 1'b0;
              mdio_o      <= 1'b1;
              mdio_oe_o   <= 1'b0;
            end else begin
              bit_cnt   <= next_bit;
              shift_q   <= {shift_q[61:0], 1'b1};
              mdio_o    <= shift_q[62];
              mdio_oe_o <= is_write || (next_bit < TA_IDX);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
